// File: rtl/seq_divider_if.sv
// Handshake bundle for seq_divider: start/ready request side plus quotient,
// remainder, done and div_by_zero result side.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor early-out: define SEQ_DIVIDER_DIV_ZERO_EN.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int unsigned    CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;
    logic             w_load;
    logic             w_last;
    logic             w_ge;
    logic [WIDTH:0]   w_r_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    logic             r_dbz;
    logic             w_dz_hit;

    assign w_dz_hit = (r_state == S_IDLE) && bus.start && (bus.divisor == '0);
`endif

    // Partial remainder is stored in WIDTH bits: after each step it is below
    // the divisor, and the borrow of the trial subtract replaces the compare.
    always_comb begin
        w_r_shift = {r_r, r_q[WIDTH-1]};
        w_diff    = w_r_shift - {1'b0, r_d};
        w_ge      = ~w_diff[WIDTH];
        w_r_next  = w_ge ? w_diff[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
        w_q_next  = {r_q[WIDTH-2:0], w_ge};
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
                if (bus.start && !w_dz_hit) begin
`else
                if (bus.start) begin
`endif
                    w_load       = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            r_dbz  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_d   <= bus.divisor;
                r_q   <= bus.dividend;
                r_r   <= '0;
                r_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_q   <= w_q_next;
                r_r   <= w_r_next;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
                r_done <= 1'b1;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
                r_dbz  <= 1'b0;
`endif
            end
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            if (w_dz_hit) begin
                r_quot <= '1;
                r_rem  <= bus.dividend;
                r_dbz  <= 1'b1;
                r_done <= 1'b1;
            end
`endif
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule
